// File: rtl/fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_wr_ctrl
//
// Write-side pointer and flag controller for an asynchronous FIFO. Runs
// entirely in the write clock domain. It keeps the binary and Gray write
// pointers, generates the memory write strobe and address, and compares its
// own pointer with the read pointer coming out of the 2-flop synchronizer to
// produce full, almost_full, the fill count and a sticky overflow flag.
//
// Parameters
//   DEPTH         FIFO entries, power of two, >= 4
//   PTR_SIZE      memory address width; pointers are PTR_SIZE+1 bits wide
//   AFULL_THRESH  almost_full asserts when the fill count is >= this value
//                 (1..DEPTH)
//
// Ports
//   clk          write-domain clock
//   reset        asynchronous, active-low reset
//   wr_en        write request from the producer
//   rptr_sync    Gray read pointer, already synchronized into clk
//   ovf_clr      clears the sticky overflow flag
//   wr_fire      memory write strobe (combinational, wr_en & ~full)
//   waddr        memory write address (low bits of the binary write pointer)
//   wptr_gray    registered Gray write pointer, to the synchronizer
//   full         registered full flag
//   almost_full  registered, fill count >= AFULL_THRESH
//   wr_count     registered fill level seen from this domain, 0..DEPTH
//   overflow     sticky, a write was attempted while full
// ---------------------------------------------------------------------------
module fifo_wr_ctrl #(
    parameter int DEPTH        = 128,
    parameter int PTR_SIZE     = $clog2(DEPTH),
    parameter int AFULL_THRESH = DEPTH - 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [PTR_SIZE:0]   rptr_sync,
    input  logic                ovf_clr,
    output logic                wr_fire,
    output logic [PTR_SIZE-1:0] waddr,
    output logic [PTR_SIZE:0]   wptr_gray,
    output logic                full,
    output logic                almost_full,
    output logic [PTR_SIZE:0]   wr_count,
    output logic                overflow
);

    // AFULL_THRESH can equal DEPTH, which still fits in PTR_SIZE+1 bits.
    localparam logic [PTR_SIZE:0] AFULL_LVL = (PTR_SIZE + 1)'(AFULL_THRESH);

    logic [PTR_SIZE:0] wbin;
    logic [PTR_SIZE:0] wbin_next;
    logic [PTR_SIZE:0] wgray_next;
    logic [PTR_SIZE:0] rbin;
    logic [PTR_SIZE:0] count_next;
    logic [PTR_SIZE:0] full_pattern;

    // Gray-to-binary conversion of the synchronized read pointer: each
    // binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= PTR_SIZE; i++) begin
            rbin[i] = ^(rptr_sync >> i);
        end
    end

    // A write while full is dropped, so the pointer simply holds.
    assign wr_fire = wr_en & ~full;
    assign waddr   = wbin[PTR_SIZE-1:0];

    // Next-state pointer math. Both the write and any read-pointer movement
    // in the same cycle fold into these values, so there is no ordering
    // between them. Wrap-around is the natural modulo of the pointer width.
    always_comb begin
        wbin_next    = wbin + {{PTR_SIZE{1'b0}}, wr_fire};
        wgray_next   = wbin_next ^ (wbin_next >> 1);
        count_next   = wbin_next - rbin;
        // Full in Gray space: the write pointer has lapped the read pointer
        // exactly once, which flips the top two Gray bits and leaves the rest.
        full_pattern = {~rptr_sync[PTR_SIZE:PTR_SIZE-1], rptr_sync[PTR_SIZE-2:0]};
    end

    // Pointer and flag registers. Flags are computed from the next-state
    // pointer so the write that fills the FIFO raises full on the same edge
    // that accepts it. Read-side frees only show up once rptr_sync moves,
    // which keeps full pessimistic by the synchronizer delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_count    <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= wgray_next;
            full        <= (wgray_next == full_pattern);
            almost_full <= (count_next >= AFULL_LVL);
            wr_count    <= count_next;
            // Setting wins over clearing so an overflow in the clear cycle
            // is never lost.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_ctrl
//
// Directed bench for fifo_wr_ctrl with DEPTH=8, AFULL_THRESH=6. The driver
// applies one vector per clock on the falling edge and pushes the output
// snapshot expected a few ns later onto a scoreboard queue. A separate monitor
// samples the DUT after each falling edge and pops one entry per cycle.
// Expected values come from a small count-based reference model, with key
// points overridden by hand-computed constants.
// ---------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

    localparam int DEPTH    = 8;
    localparam int PTR_SIZE = 3;
    localparam int AFULL    = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] rptr_sync = 4'd0;
    logic       ovf_clr = 1'b0;
    logic       wr_fire;
    logic [2:0] waddr;
    logic [3:0] wptr_gray;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_count;
    logic       overflow;

    typedef struct {
        logic       fire;
        logic [2:0] addr;
        logic [3:0] gray;
        logic       full;
        logic       af;
        logic [3:0] cnt;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    exp_t hand;
    bit   hand_pending = 1'b0;

    int n_vectors = 0;
    int n_miscompares = 0;

    // Reference model state, as seen just before the next rising edge.
    logic [3:0] m_bin = 4'd0;
    logic [3:0] m_gray = 4'd0;
    logic [3:0] m_cnt = 4'd0;
    logic       m_full = 1'b0;
    logic       m_af = 1'b0;
    logic       m_ovf = 1'b0;

    logic [3:0] prev_gray = 4'd0;

    fifo_wr_ctrl #(
        .DEPTH(DEPTH),
        .PTR_SIZE(PTR_SIZE),
        .AFULL_THRESH(AFULL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .rptr_sync(rptr_sync),
        .ovf_clr(ovf_clr),
        .wr_fire(wr_fire),
        .waddr(waddr),
        .wptr_gray(wptr_gray),
        .full(full),
        .almost_full(almost_full),
        .wr_count(wr_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_vectors++;
        if (act !== expv) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Hand-computed registered values for the next snapshot.
    task automatic expectHand(input logic [3:0] gray, input logic [3:0] cnt,
                              input logic fl, input logic af, input logic ovf);
        hand.gray    = gray;
        hand.cnt     = cnt;
        hand.full    = fl;
        hand.af      = af;
        hand.ovf     = ovf;
        hand_pending = 1'b1;
    endtask

    // Drive one cycle of inputs on the falling edge, queue the snapshot the
    // monitor should see before the next rising edge, then advance the model.
    task automatic applyStimulus(input logic rst_n, input logic we,
                                 input logic [3:0] rp, input logic clr);
        exp_t       e;
        logic       fire;
        logic [3:0] rb;
        logic [3:0] diff;
        @(negedge clk);
        reset     = rst_n;
        wr_en     = we;
        rptr_sync = rp;
        ovf_clr   = clr;
        if (!rst_n) begin
            m_bin  = 4'd0;
            m_gray = 4'd0;
            m_cnt  = 4'd0;
            m_full = 1'b0;
            m_af   = 1'b0;
            m_ovf  = 1'b0;
        end
        fire   = we & ~m_full;
        e.fire = fire;
        e.addr = m_bin[2:0];
        e.gray = m_gray;
        e.full = m_full;
        e.af   = m_af;
        e.cnt  = m_cnt;
        e.ovf  = m_ovf;
        if (hand_pending) begin
            e.gray       = hand.gray;
            e.cnt        = hand.cnt;
            e.full       = hand.full;
            e.af         = hand.af;
            e.ovf        = hand.ovf;
            hand_pending = 1'b0;
        end
        sb.push_back(e);
        if (rst_n) begin
            rb     = rp ^ (rp >> 1) ^ (rp >> 2) ^ (rp >> 3);
            m_ovf  = (we && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_bin  = m_bin + 4'(fire);
            m_gray = to_gray(m_bin);
            diff   = m_bin - rb;
            m_cnt  = diff;
            m_full = (diff == 4'd8);
            m_af   = (diff >= 4'd6);
        end
    endtask

    // Monitor: sample 3 ns after each falling edge, well clear of both edges.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                checkOutput("gray_step", 8'($countones(prev_gray ^ wptr_gray) <= 1), 8'd1);
                checkOutput("count_range", 8'(wr_count <= 4'd8), 8'd1);
            end
            prev_gray = wptr_gray;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("wr_fire", 8'(wr_fire), 8'(e.fire));
                checkOutput("waddr", 8'(waddr), 8'(e.addr));
                checkOutput("wptr_gray", 8'(wptr_gray), 8'(e.gray));
                checkOutput("full", 8'(full), 8'(e.full));
                checkOutput("almost_full", 8'(almost_full), 8'(e.af));
                checkOutput("wr_count", 8'(wr_count), 8'(e.cnt));
                checkOutput("overflow", 8'(overflow), 8'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset then idle with the read pointer at zero.
        repeat (3) applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        repeat (2) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);

        // Eight back-to-back writes fill the FIFO; almost_full after the 6th.
        for (int k = 0; k < 8; k++) begin
            if (k == 6) expectHand(4'b0101, 4'd6, 1'b0, 1'b1, 1'b0);
            applyStimulus(1'b1, 1'b1, 4'd0, 1'b0);
        end
        expectHand(4'b1100, 4'd8, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b0);
        expectHand(4'b1100, 4'd8, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);

        // One slot freed by the reader, then refilled.
        applyStimulus(1'b1, 1'b0, 4'b0001, 1'b0);
        expectHand(4'b1100, 4'd7, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 4'b0001, 1'b0);
        expectHand(4'b1101, 4'd8, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'b0001, 1'b0);

        // Reader jumps to bin 7 (count 2) while overflow is cleared.
        applyStimulus(1'b1, 1'b0, 4'b0100, 1'b1);

        // Wrap-around with the reader two behind the new write pointer.
        for (int j = 0; j < 20; j++) begin
            expectHand(to_gray(4'(9 + j)), 4'd2, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b1, to_gray(4'(8 + j)), 1'b0);
        end

        // Fill against read pointer bin 11, then overflow set/clear collision.
        repeat (6) applyStimulus(1'b1, 1'b1, 4'b1110, 1'b0);
        expectHand(4'b0010, 4'd8, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b1110, 1'b0);
        expectHand(4'b0010, 4'd8, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 4'b1110, 1'b1);
        expectHand(4'b0010, 4'd8, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'b1110, 1'b1);
        expectHand(4'b0010, 4'd8, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b1001, 1'b0);
        expectHand(4'b0010, 4'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b1001, 1'b0);

        // Asynchronous reset mid-stream, then the first write after release.
        expectHand(4'b0000, 4'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b0);
        expectHand(4'b0001, 4'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        #5;
        checkOutput("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
- Write-side pointer and flag controller for the async FIFO, clocked in the write domain.
- Sequences writes into the dual-port memory and maintains the binary and Gray write pointers.
- Compares its own pointer against the read pointer arriving from the 2-flop pointer synchronizer to produce full, almost_full, fill count and a sticky overflow flag.
- The Gray write pointer output feeds the synchronizer that crosses into the read domain.

Parameters:
- DEPTH, 128: FIFO entries; power of two, >= 4.
- PTR_SIZE, $clog2(DEPTH): memory address width; pointers are PTR_SIZE+1 bits.
- AFULL_THRESH, DEPTH-4: almost_full asserts when the fill count is >= this value; legal range 1..DEPTH.

Ports:
- clk  input  1  write-domain clock.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request from the producer.
- rptr_sync  input  PTR_SIZE+1  Gray read pointer, already synchronized into clk.
- ovf_clr  input  1  clears the sticky overflow flag.
- wr_fire  output  1  memory write strobe; combinational, wr_en & ~full.
- waddr  output  PTR_SIZE  memory write address; lower PTR_SIZE bits of the binary write pointer.
- wptr_gray  output  PTR_SIZE+1  registered Gray write pointer, to the synchronizer.
- full  output  1  registered full flag.
- almost_full  output  1  registered; asserted when count >= AFULL_THRESH.
- wr_count  output  PTR_SIZE+1  registered fill level in this domain, range 0..DEPTH.
- overflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (reset=0, asynchronous):
  - binary pointer, wptr_gray, wr_count = 0.
  - full, almost_full, overflow = 0.
  - Outputs stay at these values while reset is held low; the first update is on the first clk edge after release.
- wr_fire = wr_en & ~full. A write while full is dropped, and the pointer holds.
- Next-state values each cycle:
  - wbin_next = wbin + wr_fire, modulo 2^(PTR_SIZE+1); wrap-around is natural.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
- Registered at posedge clk:
  - wbin <= wbin_next.
  - wptr_gray <= wgray_next.
  - full <= (wgray_next == {~rptr_sync[PTR_SIZE:PTR_SIZE-1], rptr_sync[PTR_SIZE-2:0]}).
  - wr_count <= wbin_next - gray2bin(rptr_sync), modulo 2^(PTR_SIZE+1).
  - almost_full <= (wbin_next - gray2bin(rptr_sync)) >= AFULL_THRESH.
- Latency:
  - The write that fills the FIFO raises full on the same clk edge at which it is accepted.
  - Read-side frees become visible only when rptr_sync changes. full deasserts one clk after that change, and is conservative (pessimistic) by the synchronizer delay.
- wptr_gray changes by at most one bit per clk; this is mandatory for a safe crossing.
- gray2bin: b[PTR_SIZE] = g[PTR_SIZE]; b[i] = b[i+1] ^ g[i].
- overflow:
  - Set when wr_en & full.
  - Cleared when ovf_clr=1.
  - If set and clear occur in the same cycle, set wins.
- Simultaneous write and rptr_sync change in one cycle: both are folded into the same next-state computation; there is no priority issue.
- wr_count never exceeds DEPTH. A value > DEPTH indicates a corrupted rptr_sync; the bench flags it as an error.
- Reset asserted mid-operation: all state clears immediately. The read side must be reset together; a single-sided reset is unsupported.

Test Plan (bench uses DEPTH=8, PTR_SIZE=3, AFULL_THRESH=6):
1. Reset then idle, rptr_sync=0 -> all outputs 0; wr_count=0; full=0.
2. 8 back-to-back writes, rptr_sync held 0:
   - waddr steps 0..7.
   - almost_full=1 after the 6th write.
   - full=1 after the 8th write, with wptr_gray=4'b1100 and wr_count=8.
   - A 9th wr_en gives wr_fire=0, pointer unchanged, overflow=1.
3. From the state of scenario 2, drive rptr_sync=4'b0001 (bin 1) -> next clk: full=0, wr_count=7, almost_full=1. One write then refills -> full=1, wptr_gray=4'b1101.
4. Wrap-around: 20 writes interleaved with rptr_sync tracking two behind -> binary pointer passes 15→0, waddr wraps 7→0. Every wptr_gray transition differs by exactly one bit. full never asserts; wr_count stays at 2.
5. overflow=1 with ovf_clr and (wr_en & full) in the same cycle -> overflow stays 1. ovf_clr alone on the next cycle -> overflow=0.
6. Reset asserted asynchronously mid-stream (wr_count=5) -> outputs clear without waiting for a clk edge. After release, the first write drives waddr=0 and wptr_gray=4'b0001.
